lcd_host_driver: RTL and testbench

- Host-side initiator that drives the LCD controller's command/data interface (cmd, cmd_valid, datain; observes busy, output_valid, dataout).
- Accepts one operation at a time from an upstream sequencer.
- For LOAD, streams 108 image bytes from a 1-cycle-latency image ROM.
- Captures the 16-pixel output frame into a readable buffer and flags protocol errors (timeout, wrong pixel count).

---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_host_driver_if.sv | 12 +
 rtl/lcd_frame_capture.sv | 55 +++++
 rtl/lcd_host_driver.sv | 153 +++++++++++++++
 tb/tb_lcd_host_driver.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared constants for the LCD host driver: controller command codes,
// transfer sizes and FSM state encodings.
package lcd_pkg;

   localparam int IMG_SIZE    = 108;
   localparam int FRAME_PIX   = 16;
   localparam int AW          = 7;
   localparam int TIMEOUT_CYC = 255;

   localparam logic [3:0] CMD_LOAD        = 4'd0;
   localparam logic [3:0] CMD_ROT_LEFT    = 4'd1;
   localparam logic [3:0] CMD_ROT_RIGHT   = 4'd2;
   localparam logic [3:0] CMD_ZOOM_IN     = 4'd3;
   localparam logic [3:0] CMD_FIT         = 4'd4;
   localparam logic [3:0] CMD_SHIFT_LEFT  = 4'd5;
   localparam logic [3:0] CMD_SHIFT_RIGHT = 4'd6;
   localparam logic [3:0] CMD_SHIFT_UP    = 4'd7;
   localparam logic [3:0] CMD_SHIFT_DOWN  = 4'd8;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_ISSUE = 3'd1;
   localparam state_t ST_LOAD  = 3'd2;
   localparam state_t ST_WAIT  = 3'd3;
   localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/lcd_host_driver_if.sv
// Command/data bus between the host driver (master) and the LCD controller (slave).
interface lcd_host_driver_if;
   logic [3:0] cmd;
   logic       cmd_valid;
   logic [7:0] datain;
   logic       busy;
   logic       output_valid;
   logic [7:0] dataout;

   modport master (output cmd, cmd_valid, datain, input busy, output_valid, dataout);
   modport slave  (input cmd, cmd_valid, datain, output busy, output_valid, dataout);
endinterface

// File: rtl/lcd_frame_capture.sv
// Pixel capture buffer: stores up to FRAME_PIX pixels of a display burst and
// flags any burst whose length is not exactly FRAME_PIX.
module lcd_frame_capture
   import lcd_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       chk,
   input  logic [3:0] rd_idx,
   output logic [7:0] rd_data,
   output logic       err_count
);

   logic [FRAME_PIX-1:0][7:0] pix_buf_q, pix_buf_d;
   logic [4:0]                pix_count_q, pix_count_d;
   logic                      err_q, err_d;

   always_comb begin
      pix_buf_d   = pix_buf_q;
      pix_count_d = pix_count_q;
      err_d       = err_q;
      if (clr) begin
         pix_count_d = '0;
      end else if (wr_en) begin
         // Overflow pixels are dropped rather than wrapping over the frame.
         if (pix_count_q == 5'(FRAME_PIX)) begin
            err_d = 1'b1;
         end else begin
            pix_buf_d[pix_count_q[3:0]] = wr_data;
            pix_count_d                 = pix_count_q + 5'd1;
         end
      end
      if (chk && (pix_count_d != 5'(FRAME_PIX)))
         err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pix_buf_q   <= '0;
         pix_count_q <= '0;
         err_q       <= 1'b0;
      end else begin
         pix_buf_q   <= pix_buf_d;
         pix_count_q <= pix_count_d;
         err_q       <= err_d;
      end
   end

   assign rd_data   = pix_buf_q[rd_idx];
   assign err_count = err_q;

endmodule

// File: rtl/lcd_host_driver.sv
// Host-side initiator for the LCD controller: issues one command per accepted
// op, streams the image ROM on LOAD and captures the resulting pixel frame.
module lcd_host_driver
   import lcd_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 op_valid,
   input  logic [3:0]           op_code,
   output logic                 op_ready,
   output logic [AW-1:0]        img_addr,
   input  logic [7:0]           img_rdata,
   lcd_host_driver_if.master    ctrl,
   output logic                 frame_valid,
   input  logic [3:0]           frame_rd_idx,
   output logic [7:0]           frame_rd_data,
   output logic                 err_timeout,
   output logic                 err_count
);

   localparam logic [AW-1:0] ADDR_LAST = AW'(IMG_SIZE - 1);
   localparam logic [6:0]    LOAD_LAST = 7'(IMG_SIZE - 1);

   state_t        state_q, state_d;
   logic [3:0]    op_q, op_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [6:0]    load_cnt_q, load_cnt_d;
   logic [7:0]    datain_q, datain_d;
   logic [7:0]    tmo_q, tmo_d, tmo_inc;
   logic          busy_seen_q, busy_seen_d;
   logic          frame_valid_q, frame_valid_d;
   logic          err_tmo_q, err_tmo_d;
   logic          strobe, cap_clr, cap_chk, cap_wr;

   assign strobe  = (state_q == ST_ISSUE) && !ctrl.busy;
   assign tmo_inc = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
   assign cap_wr  = (state_q == ST_WAIT) && ctrl.output_valid;

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      addr_d        = addr_q;
      load_cnt_d    = load_cnt_q;
      datain_d      = datain_q;
      tmo_d         = tmo_q;
      busy_seen_d   = busy_seen_q;
      frame_valid_d = frame_valid_q;
      err_tmo_d     = err_tmo_q;
      cap_clr       = 1'b0;
      cap_chk       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            addr_d = '0;
            if (op_valid) begin
               op_d          = op_code;
               frame_valid_d = 1'b0;
               cap_clr       = 1'b1;
               tmo_d         = '0;
               state_d       = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (ctrl.busy) begin
               tmo_d = tmo_inc;
            end else begin
               // Strobe cycle counts as zero; next cycle sees one.
               tmo_d       = 8'd1;
               busy_seen_d = 1'b0;
               load_cnt_d  = '0;
               if (op_q == CMD_LOAD) begin
                  addr_d  = AW'(1);
                  state_d = ST_LOAD;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_LOAD: begin
            tmo_d      = tmo_inc;
            datain_d   = img_rdata;
            load_cnt_d = load_cnt_q + 7'd1;
            if (ctrl.busy) busy_seen_d = 1'b1;
            if (addr_q != ADDR_LAST) addr_d = addr_q + AW'(1);
            if (load_cnt_q == LOAD_LAST) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            tmo_d = tmo_inc;
            if (ctrl.busy) busy_seen_d = 1'b1;
            if (busy_seen_q && !ctrl.busy) begin
               cap_chk = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            frame_valid_d = 1'b1;
            state_d       = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if ((state_q inside {ST_ISSUE, ST_LOAD, ST_WAIT}) && (state_d != ST_DONE) &&
          (tmo_d == 8'(TIMEOUT_CYC))) begin
         err_tmo_d = 1'b1;
         state_d   = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         op_q          <= '0;
         addr_q        <= '0;
         load_cnt_q    <= '0;
         datain_q      <= '0;
         tmo_q         <= '0;
         busy_seen_q   <= 1'b0;
         frame_valid_q <= 1'b0;
         err_tmo_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         addr_q        <= addr_d;
         load_cnt_q    <= load_cnt_d;
         datain_q      <= datain_d;
         tmo_q         <= tmo_d;
         busy_seen_q   <= busy_seen_d;
         frame_valid_q <= frame_valid_d;
         err_tmo_q     <= err_tmo_d;
      end
   end

   lcd_frame_capture u_cap (
      .clk       (clk),
      .reset     (reset),
      .clr       (cap_clr),
      .wr_en     (cap_wr),
      .wr_data   (ctrl.dataout),
      .chk       (cap_chk),
      .rd_idx    (frame_rd_idx),
      .rd_data   (frame_rd_data),
      .err_count (err_count)
   );

   // ROM data lands the cycle after its address, so LOAD presents it directly
   // and the register only holds the last byte afterwards.
   assign ctrl.datain    = (state_q == ST_LOAD) ? img_rdata : datain_q;
   assign ctrl.cmd       = strobe ? op_q : 4'd0;
   assign ctrl.cmd_valid = strobe;
   assign op_ready       = (state_q == ST_IDLE);
   assign img_addr       = addr_q;
   assign frame_valid    = frame_valid_q;
   assign err_timeout    = err_tmo_q;

endmodule

// File: tb/tb_lcd_host_driver.sv
// Directed bench for lcd_host_driver with a queue scoreboard for load bytes and frames.
module tb_lcd_host_driver;
   import lcd_pkg::*;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          op_valid = 1'b0;
   logic [3:0]    op_code = '0;
   logic          op_ready;
   logic [AW-1:0] img_addr;
   logic [7:0]    img_rdata;
   logic          frame_valid;
   logic [3:0]    frame_rd_idx = '0;
   logic [7:0]    frame_rd_data;
   logic          err_timeout, err_count;

   int n_chk = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   int frm [3][16] = '{
      '{13,16,19,22,37,40,43,46,61,64,67,70,85,88,91,94},
      '{85,61,37,13,88,64,40,16,91,67,43,19,94,70,46,22},
      '{40,41,42,43,52,53,54,55,64,65,66,67,76,77,78,79}};

   lcd_host_driver_if ctrl ();

   lcd_host_driver dut (
      .clk           (clk),
      .reset         (reset),
      .op_valid      (op_valid),
      .op_code       (op_code),
      .op_ready      (op_ready),
      .img_addr      (img_addr),
      .img_rdata     (img_rdata),
      .ctrl          (ctrl),
      .frame_valid   (frame_valid),
      .frame_rd_idx  (frame_rd_idx),
      .frame_rd_data (frame_rd_data),
      .err_timeout   (err_timeout),
      .err_count     (err_count)
   );

   always #5 clk = ~clk;

   // Image ROM model, rom[i] = i, one cycle of read latency.
   always @(posedge clk) img_rdata <= 8'(img_addr);

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_chk++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
      end
   endtask

   // Run one op against the controller model emitting npix pixels from frame fsel.
   task automatic do_op(input logic [3:0] code, input int fsel, input int npix, input logic exp_err);
      logic strobed;
      int   w;
      @(negedge clk);
      op_valid = 1'b1;
      op_code  = code;
      #1 chk("op_ready_idle", 32'(op_ready), 32'd1);
      @(negedge clk);
      op_valid = 1'b0;
      #1;
      chk("cmd_valid_T", 32'(ctrl.cmd_valid), 32'd1);
      chk("cmd_T", 32'(ctrl.cmd), 32'(code));
      chk("frame_valid_cleared", 32'(frame_valid), 32'd0);
      if (code == CMD_LOAD) begin
         chk("img_addr_T", 32'(img_addr), 32'd0);
         for (int k = 0; k < IMG_SIZE; k++) exp_q.push_back(8'(k));
         strobed = 1'b0;
         for (int k = 0; k < IMG_SIZE; k++) begin
            @(negedge clk);
            ctrl.busy = 1'b1;
            #1;
            if (ctrl.cmd_valid) strobed = 1'b1;
            chk("datain", 32'(ctrl.datain), 32'(exp_q.pop_front()));
         end
         chk("cmd_valid_single", 32'(strobed), 32'd0);
         chk("img_addr_hold", 32'(img_addr), 32'(IMG_SIZE - 1));
      end
      for (int i = 0; i < npix; i++) begin
         @(negedge clk);
         ctrl.busy         = 1'b1;
         ctrl.output_valid = 1'b1;
         ctrl.dataout      = (i < FRAME_PIX) ? 8'(frm[fsel][i]) : 8'hEE;
         if (i < FRAME_PIX) exp_q.push_back(8'(frm[fsel][i]));
      end
      @(negedge clk);
      ctrl.output_valid = 1'b0;
      ctrl.busy         = 1'b0;
      #1;
      if (code == CMD_LOAD) chk("datain_hold", 32'(ctrl.datain), 32'(IMG_SIZE - 1));
      w = 0;
      while (!frame_valid && w < 10) begin
         @(negedge clk);
         #1;
         w++;
      end
      chk("frame_valid", 32'(frame_valid), 32'd1);
      for (int i = 0; i < FRAME_PIX && i < npix; i++) begin
         frame_rd_idx = 4'(i);
         #1 chk("frame_pix", 32'(frame_rd_data), 32'(exp_q.pop_front()));
      end
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      chk("err_count", 32'(err_count), 32'(exp_err));
      chk("err_timeout", 32'(err_timeout), 32'd0);
   endtask

   initial begin
      logic strobed;
      int   n;
      ctrl.busy         = 1'b0;
      ctrl.output_valid = 1'b0;
      ctrl.dataout      = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_op_ready", 32'(op_ready), 32'd1);
      chk("rst_cmd_valid", 32'(ctrl.cmd_valid), 32'd0);
      chk("rst_cmd", 32'(ctrl.cmd), 32'd0);
      chk("rst_datain", 32'(ctrl.datain), 32'd0);
      chk("rst_img_addr", 32'(img_addr), 32'd0);
      chk("rst_frame_valid", 32'(frame_valid), 32'd0);
      chk("rst_err_timeout", 32'(err_timeout), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_frame_data", 32'(frame_rd_data), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      do_op(CMD_LOAD, 0, 16, 1'b0);
      do_op(CMD_ROT_RIGHT, 1, 16, 1'b0);
      do_op(CMD_LOAD, 0, 16, 1'b0);
      do_op(CMD_ZOOM_IN, 2, 16, 1'b0);

      // Wrong burst lengths; err_count is sticky.
      do_op(CMD_LOAD, 0, 17, 1'b1);
      do_op(CMD_FIT, 0, 15, 1'b1);

      // Busy stuck high from before accept: no strobe, timeout back to IDLE.
      @(negedge clk);
      ctrl.busy = 1'b1;
      op_valid  = 1'b1;
      op_code   = CMD_FIT;
      @(negedge clk);
      op_valid = 1'b0;
      strobed  = 1'b0;
      n        = 0;
      while (n < 300) begin
         #1;
         if (op_ready) break;
         if (ctrl.cmd_valid) strobed = 1'b1;
         @(negedge clk);
         n++;
      end
      chk("tmo_cycles", 32'(n), 32'd255);
      chk("tmo_no_strobe", 32'(strobed), 32'd0);
      chk("tmo_err_timeout", 32'(err_timeout), 32'd1);
      chk("tmo_frame_valid", 32'(frame_valid), 32'd0);
      @(negedge clk);
      ctrl.busy = 1'b0;

      // Reset during the strobe cycle drops cmd_valid without a clock.
      @(negedge clk);
      op_valid = 1'b1;
      op_code  = CMD_ROT_LEFT;
      @(negedge clk);
      op_valid = 1'b0;
      #1 chk("strobe_before_rst", 32'(ctrl.cmd_valid), 32'd1);
      reset = 1'b0;
      #1 chk("strobe_async_drop", 32'(ctrl.cmd_valid), 32'd0);
      chk("rst_clears_err", 32'(err_timeout), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Reset at T+50 of a LOAD.
      @(negedge clk);
      op_valid = 1'b1;
      op_code  = CMD_LOAD;
      @(negedge clk);
      op_valid = 1'b0;
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk);
         ctrl.busy = 1'b1;
      end
      #1 chk("mid_load_datain", 32'(ctrl.datain), 32'd49);
      reset = 1'b0;
      #1;
      chk("mid_rst_cmd_valid", 32'(ctrl.cmd_valid), 32'd0);
      chk("mid_rst_op_ready", 32'(op_ready), 32'd1);
      chk("mid_rst_frame_valid", 32'(frame_valid), 32'd0);
      chk("mid_rst_img_addr", 32'(img_addr), 32'd0);
      chk("mid_rst_err_count", 32'(err_count), 32'd0);
      @(negedge clk);
      ctrl.busy = 1'b0;
      reset     = 1'b1;
      do_op(CMD_LOAD, 0, 16, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
